// File: rtl/dma_rd_streamer.sv
// Read-side descriptor streamer: splits one (addr, bytes) descriptor
// into AXI INCR read-burst requests bounded by MAX_BEATS and 4 KB pages.
module dma_rd_streamer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                dma_start_i,
  input  logic                dma_abort_i,
  input  logic [ADDR_W-1:0]   src_addr_i,
  input  logic [31:0]         num_bytes_i,
  output logic                req_valid_o,
  input  logic                req_ready_i,
  output logic [ADDR_W-1:0]   req_addr_o,
  output logic [7:0]          req_alen_o,
  output logic [2:0]          req_size_o,
  output logic [DATA_W/8-1:0] req_strb_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);

  localparam logic [12:0]       MAX_B  = 13'(MAX_BEATS);
  localparam logic [ADDR_W-1:0] A_MASK = ~ADDR_W'(BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    TAIL,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       beats_q, beats_d;
  logic [LB-1:0]     tail_q, tail_d;
  logic              zl_q, zl_d;

  logic [12:0]       room;
  logic [12:0]       beats_cap;
  logic [12:0]       n_min;
  logic [12:0]       n;
  logic [ADDR_W-1:0] step;
  logic [31:0]       start_beats;
  logic              hs;

  // Beats left before the next 4 KB page (addr_q is beat aligned).
  assign room = (13'd4096 - {1'b0, addr_q[11:0]}) >> LB;

  assign beats_cap = (beats_q > 32'd4096) ? 13'd4096
                                          : beats_q[12:0];

  assign n_min = (beats_cap < MAX_B) ? beats_cap : MAX_B;
  assign n     = (room < n_min) ? room : n_min;
  assign step  = ADDR_W'(n) << LB;

  assign start_beats = num_bytes_i >> LB;
  assign hs          = req_valid_o & req_ready_i;
  assign req_size_o  = 3'(LB);

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    beats_d     = beats_q;
    tail_d      = tail_q;
    zl_d        = zl_q;
    req_valid_o = 1'b0;
    req_addr_o  = '0;
    req_alen_o  = '0;
    req_strb_o  = '0;
    busy_o      = (state_q != IDLE);
    done_o      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (dma_start_i) begin
          addr_d  = src_addr_i & A_MASK;
          beats_d = start_beats;
          tail_d  = num_bytes_i[LB-1:0];
          zl_d    = 1'b0;
          if (start_beats != '0) begin
            state_d = DISPATCH;
          end else if (num_bytes_i[LB-1:0] != '0) begin
            state_d = TAIL;
          end else begin
            state_d = DONE;
            zl_d    = 1'b1;
          end
        end
      end

      DISPATCH: begin
        req_valid_o = 1'b1;
        req_addr_o  = addr_q;
        req_alen_o  = 8'(n - 13'd1);
        req_strb_o  = '1;
        if (hs) begin
          addr_d  = addr_q + step;
          beats_d = beats_q - 32'(n);
          if (beats_d == '0) begin
            state_d = (tail_q != '0) ? TAIL : DONE;
          end
        end
      end

      TAIL: begin
        req_valid_o = 1'b1;
        req_addr_o  = addr_q;
        req_strb_o  = ~({BYTES{1'b1}} << tail_q);
        if (hs) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // A zero-length descriptor lingers one extra busy cycle.
        if (zl_q) begin
          zl_d = 1'b0;
        end else begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (dma_abort_i) begin
      state_d = IDLE;
      zl_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beats_q <= '0;
      tail_q  <= '0;
      zl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beats_q <= beats_d;
      tail_q  <= tail_d;
      zl_q    <= zl_d;
    end
  end

endmodule

// File: tb/tb_dma_rd_streamer.sv
// Bench for dma_rd_streamer: directed cases plus random descriptors
// checked against a queue of expected bursts.
module tb_dma_rd_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] src_addr;
  logic [31:0] num_bytes;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_alen;
  logic [2:0]  req_size;
  logic [3:0]  req_strb;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  l;
    logic [3:0]  s;
  } req_t;

  req_t exp_q[$];

  dma_rd_streamer #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_BEATS(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dma_start_i(start),
    .dma_abort_i(abort),
    .src_addr_i(src_addr),
    .num_bytes_i(num_bytes),
    .req_valid_o(req_valid),
    .req_ready_i(req_ready),
    .req_addr_o(req_addr),
    .req_alen_o(req_alen),
    .req_size_o(req_size),
    .req_strb_o(req_strb),
    .busy_o(busy),
    .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Expected burst list: 4-byte beats, at most 16 per burst,
  // never past a 4 KB page, partial last beat alone.
  function automatic void build_model(input logic [31:0] a0,
                                      input logic [31:0] nb);
    logic [31:0] a;
    longint      beats;
    longint      room;
    longint      k;
    int          tail;
    req_t        r;
    exp_q.delete();
    a     = a0 & ~32'h3;
    beats = nb / 4;
    tail  = int'(nb % 4);
    while (beats > 0) begin
      room = (4096 - (a % 4096)) / 4;
      k = 16;
      if (beats < k) k = beats;
      if (room < k) k = room;
      r.a = a;
      r.l = 8'(k - 1);
      r.s = 4'hF;
      exp_q.push_back(r);
      a = a + 32'(k * 4);
      beats = beats - k;
    end
    if (tail != 0) begin
      r.a = a;
      r.l = 8'd0;
      r.s = 4'((1 << tail) - 1);
      exp_q.push_back(r);
    end
  endfunction

  task automatic run_xfer(input logic [31:0] a,
                          input logic [31:0] nb,
                          input int stall,
                          input int pct);
    req_t r;
    req_t popped;
    int   cyc;
    build_model(a, nb);
    @(negedge clk);
    src_addr  = a;
    num_bytes = nb;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (exp_q.size() == 0) begin
      chk("zl_valid_c1", 64'(req_valid), 64'd0);
      chk("zl_busy_c1", 64'(busy), 64'd1);
      chk("zl_done_c1", 64'(done), 64'd0);
      @(negedge clk);
      chk("zl_valid_c2", 64'(req_valid), 64'd0);
      chk("zl_busy_c2", 64'(busy), 64'd1);
      chk("zl_done_c2", 64'(done), 64'd1);
      @(negedge clk);
      chk("zl_busy_c3", 64'(busy), 64'd0);
      chk("zl_done_c3", 64'(done), 64'd0);
      return;
    end
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 4000) begin
      r = exp_q[0];
      chk("req_valid", 64'(req_valid), 64'd1);
      chk("req_addr", 64'(req_addr), 64'(r.a));
      chk("req_alen", 64'(req_alen), 64'(r.l));
      chk("req_strb", 64'(req_strb), 64'(r.s));
      chk("busy", 64'(busy), 64'd1);
      chk("done_early", 64'(done), 64'd0);
      if (cyc < stall)
        req_ready = 1'b0;
      else
        req_ready = ($urandom_range(0, 99) < pct);
      if (req_ready) popped = exp_q.pop_front();
      cyc++;
      @(negedge clk);
    end
    req_ready = 1'b0;
    chk("drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("done_pulse", 64'(done), 64'd1);
    chk("valid_at_done", 64'(req_valid), 64'd0);
    @(negedge clk);
    chk("done_clear", 64'(done), 64'd0);
    chk("busy_clear", 64'(busy), 64'd0);
  endtask

  task automatic cut_case(input bit use_rst);
    @(negedge clk);
    src_addr  = 32'h0;
    num_bytes = 32'd256;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("cut_valid0", 64'(req_valid), 64'd1);
    chk("cut_addr0", 64'(req_addr), 64'h0);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    chk("cut_addr1", 64'(req_addr), 64'h40);
    if (use_rst) rst = 1'b1;
    else abort = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    abort = 1'b0;
    chk("cut_valid", 64'(req_valid), 64'd0);
    chk("cut_busy", 64'(busy), 64'd0);
    chk("cut_done", 64'(done), 64'd0);
    @(negedge clk);
    chk("cut_done2", 64'(done), 64'd0);
    chk("cut_busy2", 64'(busy), 64'd0);
    run_xfer(32'h3000, 32'd4, 0, 100);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rn;
    rst       = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    src_addr  = '0;
    num_bytes = '0;
    req_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 64'(req_valid), 64'd0);
    chk("rst_addr", 64'(req_addr), 64'd0);
    chk("rst_alen", 64'(req_alen), 64'd0);
    chk("rst_strb", 64'(req_strb), 64'd0);
    chk("rst_size", 64'(req_size), 64'd2);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    run_xfer(32'h1000, 32'd64, 0, 100);
    run_xfer(32'h0FF8, 32'd32, 0, 100);
    run_xfer(32'h2003, 32'd10, 0, 100);
    run_xfer(32'h0000, 32'd128, 5, 100);
    run_xfer(32'h0000, 32'd0, 0, 100);
    cut_case(1'b0);
    cut_case(1'b1);
    run_xfer(32'hFFFF_FFF0, 32'd40, 0, 100);
    run_xfer(32'h0000_5FFC, 32'd3, 0, 60);

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1)
        ra[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      rn = 32'($urandom_range(0, 300));
      run_xfer(ra, rn, 0, 65);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
